// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD text writer.
package lcd_pkg;

    typedef enum logic [2:0] {
        StScan,
        StReq,
        StClrReq,
        StAck,
        StDone
    } lcd_state_e;

    localparam int unsigned NUM_CELLS  = 32;
    localparam logic [7:0]  LINE0_BASE = 8'h80;
    localparam logic [7:0]  LINE1_BASE = 8'hC0;
    localparam logic [7:0]  SPACE_CHAR = 8'h20;

    typedef logic [4:0] cell_idx_t;

    // Cell index is {row, col}; the row bit selects the DDRAM line base.
    function automatic logic [7:0] cell_to_addr(input cell_idx_t idx);
        return (idx[4] ? LINE1_BASE : LINE0_BASE) | {4'h0, idx[3:0]};
    endfunction

endpackage

// File: rtl/lcd_text_ram.sv
// 32-cell text frame buffer with per-cell dirty tracking and bulk clear.
module lcd_text_ram
    import lcd_pkg::*;
#(
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  cell_idx_t  wr_idx_i,
    input  logic [7:0] wr_char_i,
    input  logic       clear_i,
    input  cell_idx_t  rd_idx_i,
    input  logic       dirty_clr_i,
    output logic [7:0] rd_char_o,
    output logic       rd_dirty_o,
    output logic       any_dirty_o
);

    logic [7:0]           mem_q [NUM_CELLS];
    logic [7:0]           mem_d [NUM_CELLS];
    logic [NUM_CELLS-1:0] dirty_q, dirty_d;

    // Order matters: bulk clear, then the dirty-bit clear, then the host write,
    // so a write always survives and a same-cycle set beats a clear.
    always_comb begin
        mem_d   = mem_q;
        dirty_d = dirty_q;
        if (clear_i) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                mem_d[i] = FILL_CHAR;
            end
            dirty_d = '0;
        end
        if (dirty_clr_i) begin
            dirty_d[rd_idx_i] = 1'b0;
        end
        if (wr_en_i) begin
            mem_d[wr_idx_i]   = wr_char_i;
            dirty_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
                mem_q[i] <= FILL_CHAR;
            end
            dirty_q <= '1;
        end else begin
            mem_q   <= mem_d;
            dirty_q <= dirty_d;
        end
    end

    assign rd_char_o   = mem_q[rd_idx_i];
    assign rd_dirty_o  = dirty_q[rd_idx_i];
    assign any_dirty_o = |dirty_q;

endmodule

// File: rtl/lcd_text_writer.sv
// Streams dirty cells of a 2x16 text buffer to the LCD controller over START/CLEAR/BUSY.
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int unsigned NUM_COLS   = 16,
    parameter logic [7:0]  SPACE_CHAR = lcd_pkg::SPACE_CHAR
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  logic       i_wr_row,
    input  logic [3:0] i_wr_col,
    input  logic [7:0] i_wr_char,
    input  logic       i_clear,
    input  logic       i_lcd_busy,
    output logic       o_lcd_start,
    output logic       o_lcd_clear,
    output logic [7:0] o_lcd_address,
    output logic [7:0] o_lcd_character,
    output logic       o_synced
);

    localparam int unsigned NumCells = 2 * NUM_COLS;

    lcd_state_e state_q, state_d;
    cell_idx_t  ptr_q, ptr_d;
    logic       clr_pend_q, clr_pend_d;
    logic       xfer_clr_q, xfer_clr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] char_q, char_d;
    logic       latch;
    logic [7:0] rd_char;
    logic       rd_dirty;
    logic       any_dirty;

    lcd_text_ram #(
        .FILL_CHAR (SPACE_CHAR)
    ) u_ram (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .wr_en_i     (i_wr_en),
        .wr_idx_i    ({i_wr_row, i_wr_col}),
        .wr_char_i   (i_wr_char),
        .clear_i     (i_clear),
        .rd_idx_i    (ptr_q),
        .dirty_clr_i (latch),
        .rd_char_o   (rd_char),
        .rd_dirty_o  (rd_dirty),
        .any_dirty_o (any_dirty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StScan;
            ptr_q      <= '0;
            clr_pend_q <= 1'b0;
            xfer_clr_q <= 1'b0;
            addr_q     <= LINE0_BASE;
            char_q     <= SPACE_CHAR;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            clr_pend_q <= clr_pend_d;
            xfer_clr_q <= xfer_clr_d;
            addr_q     <= addr_d;
            char_q     <= char_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        clr_pend_d = clr_pend_q;
        xfer_clr_d = xfer_clr_q;
        addr_d     = addr_q;
        char_d     = char_q;
        latch      = 1'b0;
        unique case (state_q)
            StScan: begin
                if (clr_pend_q && !i_lcd_busy) begin
                    xfer_clr_d = 1'b1;
                    state_d    = StClrReq;
                end else if (rd_dirty && !i_lcd_busy) begin
                    latch      = 1'b1;
                    xfer_clr_d = 1'b0;
                    addr_d     = cell_to_addr(ptr_q);
                    char_d     = rd_char;
                    state_d    = StReq;
                end else begin
                    ptr_d = ptr_q + 5'd1;
                end
            end
            StReq: state_d = StAck;
            StClrReq: begin
                clr_pend_d = 1'b0;
                state_d    = StAck;
            end
            // Controller BUSY is registered, so it lags START/CLEAR by a cycle.
            StAck: begin
                if (i_lcd_busy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!i_lcd_busy) begin
                    state_d = StScan;
                    if (!xfer_clr_q) begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            default: state_d = StScan;
        endcase
        if (i_clear) begin
            clr_pend_d = 1'b1;
        end
    end

    always_comb begin
        o_lcd_start     = (state_q == StReq);
        o_lcd_clear     = (state_q == StClrReq);
        o_lcd_address   = addr_q;
        o_lcd_character = char_q;
        o_synced        = (state_q == StScan) && !any_dirty && !clr_pend_q && (NumCells == 32);
    end

endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Upstream feeder for the character-LCD controller on the DE2-115 board. It holds a 2x16 text frame buffer that the host writes at any time, tracks which cells changed, and streams only the dirty cells to the LCD controller over its START/CLEAR/BUSY handshake. It also translates each cell index into the LCD DDRAM set-address command. It sits between the game/display logic and the LCD controller, so the host never has to handle LCD timing or busy polling.

## Interface
Parameters:
- NUM_COLS, 16, characters per line (fixed at 16; the line address math depends on it)
- SPACE_CHAR, 8'h20, fill character used at reset and on clear

Ports:
- i_clk  in  1  system clock; all logic is on its rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_wr_en  in  1  host write strobe, one cell per cycle
- i_wr_row  in  1  row select: 0 = top line, 1 = bottom line
- i_wr_col  in  4  column, 0..15
- i_wr_char  in  8  character code
- i_clear  in  1  one-cycle pulse: blank the buffer and clear the panel
- i_lcd_busy  in  1  BUSY from the LCD controller
- o_lcd_start  out  1  START pulse to the LCD controller
- o_lcd_clear  out  1  CLEAR pulse to the LCD controller
- o_lcd_address  out  8  DDRAM set-address command
- o_lcd_character  out  8  character to write
- o_synced  out  1  high when no cell is dirty, no clear is pending and the FSM is in SCAN

## Operation
- Storage: a 32x8 buffer plus a 32-bit dirty vector. Cell index = {row, col}.
- Reset: every cell is SPACE_CHAR and every dirty bit is 1, so the whole panel is painted once the controller finishes booting.
- Host write: stores i_wr_char and sets the cell's dirty bit.
- i_clear: sets every cell to SPACE_CHAR, clears every dirty bit and sets clr_pend.
  - A write in the same cycle as i_clear is applied after the clear. That cell keeps the new character and stays dirty.
- Address mapping: row 0 → 8'h80 | col; row 1 → 8'hC0 | col.
- FSM states:
  - SCAN
    - If clr_pend is set and i_lcd_busy is 0: go to CLR_REQ.
    - Otherwise, if dirty[ptr] is 1 and i_lcd_busy is 0: latch the address and the character of cell ptr, clear dirty[ptr], go to REQ.
    - Otherwise: ptr ← ptr+1 (5-bit, wraps 31→0).
  - REQ: o_lcd_start = 1 for exactly this cycle. Go to ACK.
  - CLR_REQ: o_lcd_clear = 1 for exactly this cycle, clr_pend ← 0. Go to ACK.
  - ACK: wait for i_lcd_busy = 1, then go to DONE.
  - DONE: wait for i_lcd_busy = 0, then go to SCAN. On a character write, ptr ← ptr+1 when leaving DONE.
- A host write to the cell being transmitted sets its dirty bit again, because the bit was already cleared at latch time. That cell is resent on a later scan. When a set and a clear of the same dirty bit land in the same cycle, the set wins.
- An i_clear while a write is in flight does not abort that write. The clear is issued on the next visit to SCAN, and because the panel is cleared afterwards, the in-flight character ends up blank.
- o_lcd_address and o_lcd_character are registered and held from latch until the next latch. The controller samples them several cycles after START.

## Timing
- Reset values: o_lcd_start = 0, o_lcd_clear = 0, o_lcd_address = 8'h80, o_lcd_character = SPACE_CHAR, o_synced = 0, ptr = 0, state = SCAN, clr_pend = 0.
- BUSY from the controller is registered, so it rises one cycle after START or CLEAR is sampled. ACK absorbs that delay.
- Nothing is issued while i_lcd_busy is 1, which includes the controller's boot delay.
- Latency from a write to the matching START is at most 33 cycles plus the controller's busy time for any in-flight transfer: at most 32 cycles to scan around to the cell, plus 1 for REQ.
- Each transfer costs 3 cycles of overhead (REQ, ACK, DONE exit) on top of the controller's busy period.
- i_rst asserted mid-transfer returns the block to reset values immediately. Any in-flight LCD transfer is abandoned, and the full repaint restarts.

## Structure
- lcd_pkg holds:
  - the state enum (SCAN, REQ, CLR_REQ, ACK, DONE)
  - LINE0_BASE = 8'h80
  - LINE1_BASE = 8'hC0
  - SPACE_CHAR
- Sub-module lcd_text_ram: the 32x8 buffer and dirty vector. It has a host write port, a bulk clear, a read at ptr, and a dirty-bit clear port with the set-wins rule.
- The top level holds the FSM, ptr and the output registers.

## Test plan
- Reset with the busy model held high for 100 cycles, then released → exactly 32 STARTs in order.
  - Addresses 8'h80..8'h8F, then 8'hC0..8'hCF, all with character 8'h20.
  - o_synced rises after the 32nd transfer completes.
- After sync, write row 1 / col 5 = 8'h41 → one START with address 8'hC5 and character 8'h41, within 33 cycles of the model going idle.
- Write the same cell twice while its transfer is in flight (8'h41, then 8'h42) → a second START for that cell with 8'h42. The last value always reaches the panel.
- i_clear in the same cycle as a write to row 0 / col 0 = 8'h5A → one CLEAR pulse, then one START with address 8'h80 and character 8'h5A, and no other STARTs.
- Busy model that delays its BUSY rise by 1 to 3 cycles → still one START per dirty cell; no double issue from ACK.
- Assert i_rst in the middle of DONE → outputs at their reset values on the next edge, and the full 32-cell repaint repeats.
